pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 37 +++
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer_ret_stack.sv | 64 ++++++
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM states, default
// sizes and the control-priority decode used by the top level.
package pc_seq_pkg;

    localparam int PC_W_DEF     = 7;
    localparam int RS_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

    // Encoded winner among the simultaneous control requests.
    typedef enum logic [2:0] {
        CTL_HALT   = 3'd0,
        CTL_STALL  = 3'd1,
        CTL_RETURN = 3'd2,
        CTL_CALL   = 3'd3,
        CTL_JUMP   = 3'd4,
        CTL_BRANCH = 3'd5,
        CTL_SEQ    = 3'd6
    } ctl_e;

    function automatic ctl_e decode_ctl(input logic halt, input logic stall,
                                        input logic ret, input logic call,
                                        input logic jump, input logic branch);
        if (halt)        return CTL_HALT;
        else if (stall)  return CTL_STALL;
        else if (ret)    return CTL_RETURN;
        else if (call)   return CTL_CALL;
        else if (jump)   return CTL_JUMP;
        else if (branch) return CTL_BRANCH;
        else             return CTL_SEQ;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and fetch-address bundle between the decode stage and the sequencer.
interface pc_sequencer_if #(parameter int PC_W = pc_seq_pkg::PC_W_DEF);

    logic            Stall;
    logic            Branch;
    logic [PC_W-1:0] BranchOffset;
    logic            Jump;
    logic [PC_W-1:0] JumpTarget;
    logic            Call;
    logic            Return;
    logic            Halt;
    logic [PC_W-1:0] PCin;
    logic            Valid;
    logic            Halted;
    logic            RsOverflow;
    logic            RsUnderflow;

    modport master (
        output Stall, Branch, BranchOffset, Jump, JumpTarget, Call, Return, Halt,
        input  PCin, Valid, Halted, RsOverflow, RsUnderflow
    );

    modport slave (
        input  Stall, Branch, BranchOffset, Jump, JumpTarget, Call, Return, Halt,
        output PCin, Valid, Halted, RsOverflow, RsUnderflow
    );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Circular LIFO return-address stack; a push when full overwrites the oldest
// entry, a pop when empty changes nothing and only raises the strobe.
module ret_stack #(
    parameter int PC_W  = 7,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [PC_W-1:0]                push_data,
    output logic [PC_W-1:0]                pop_data,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow,
    output logic                           underflow,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PC_W-1:0]  stack_mem [DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_idx;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign overflow  = push & full;
    assign underflow = pop & empty;
    assign pop_data  = stack_mem[top_q];
    assign count     = count_q;
    // Power-of-two depth lets the slot index wrap onto the oldest entry.
    assign wr_idx    = top_q + PTR_W'(1);

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        if (push) begin
            top_d = wr_idx;
            if (!full) count_d = count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack_mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential advance, relative branch, jump,
// call/return through a return stack, one-cycle flush bubble and halt.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int RS_DEPTH = RS_DEPTH_DEF
) (
    input  logic          Clock,
    input  logic          Reset,
    pc_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    // Set by reset so the first unstalled edge presents address 0 without incrementing.
    logic            boot_q, boot_d;

    ctl_e             ctl;
    logic [PC_W-1:0]  pc_inc;
    logic             rs_push, rs_pop;
    logic [PC_W-1:0]  rs_data;
    logic             rs_full, rs_empty, rs_ovf, rs_unf;
    logic [CNT_W-1:0] rs_count;

    assign ctl    = decode_ctl(bus.Halt, bus.Stall, bus.Return, bus.Call,
                               bus.Jump, bus.Branch);
    assign pc_inc = pc_q + PC_W'(1);

    ret_stack #(.PC_W(PC_W), .DEPTH(RS_DEPTH)) u_rs (
        .clk       (Clock),
        .rst       (Reset),
        .push      (rs_push),
        .pop       (rs_pop),
        .push_data (pc_inc),
        .pop_data  (rs_data),
        .full      (rs_full),
        .empty     (rs_empty),
        .overflow  (rs_ovf),
        .underflow (rs_unf),
        .count     (rs_count)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        boot_d   = boot_q;
        rs_push  = 1'b0;
        rs_pop   = 1'b0;
        if (state_q != ST_HALT) begin
            if (ctl != CTL_STALL) boot_d = 1'b0;
            unique case (ctl)
                CTL_HALT: begin
                    state_d  = ST_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end
                CTL_STALL: ;
                CTL_RETURN: begin
                    rs_pop = 1'b1;
                    pc_d   = rs_empty ? pc_inc : rs_data;
                end
                CTL_CALL: begin
                    rs_push = 1'b1;
                    pc_d    = bus.JumpTarget;
                end
                CTL_JUMP:   pc_d = bus.JumpTarget;
                CTL_BRANCH: pc_d = pc_q + bus.BranchOffset;
                default: begin
                    pc_d    = boot_q ? pc_q : pc_inc;
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                end
            endcase
            if (ctl inside {CTL_RETURN, CTL_CALL, CTL_JUMP, CTL_BRANCH}) begin
                state_d = ST_FLUSH;
                valid_d = 1'b0;
            end
        end
        ovf_d = ovf_q | rs_ovf;
        unf_d = unf_q | rs_unf;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_FLUSH;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            boot_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            boot_q   <= boot_d;
        end
    end

    assign bus.PCin        = pc_q;
    assign bus.Valid       = valid_q;
    assign bus.Halted      = halted_q;
    assign bus.RsOverflow  = ovf_q;
    assign bus.RsUnderflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, wrap, branch, call/return,
// stack overflow/underflow, stall, halt and reset out of halt.
module tb_pc_sequencer;

    localparam int PC_W = 7;

    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .RS_DEPTH(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.Stall        = 1'b0;
        bus.Branch       = 1'b0;
        bus.BranchOffset = '0;
        bus.Jump         = 1'b0;
        bus.JumpTarget   = '0;
        bus.Call         = 1'b0;
        bus.Return       = 1'b0;
        bus.Halt         = 1'b0;
    endtask

    task automatic expect_pc(input string tag, input logic [6:0] pc, input logic v);
        $display("%s pc=%02h valid=%0b halted=%0b cnt=%0d", tag, bus.PCin, bus.Valid,
                 bus.Halted, dut.rs_count);
        chk({tag, "_pc"}, 32'(bus.PCin), 32'(pc));
        chk({tag, "_valid"}, 32'(bus.Valid), 32'(v));
    endtask

    task automatic expect_cnt(input string tag, input int n);
        chk({tag, "_cnt"}, 32'(dut.rs_count), 32'(n));
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        #2;
        // Reset state
        expect_pc("reset", 7'h00, 1'b0);
        chk("reset_halted", 32'(bus.Halted), 0);
        chk("reset_ovf", 32'(bus.RsOverflow), 0);
        chk("reset_unf", 32'(bus.RsUnderflow), 0);
        expect_cnt("reset", 0);
        repeat (2) tick();
        Reset = 1'b0;

        // First edge out of reset fetches 0, then free-running with wrap
        tick();
        expect_pc("boot", 7'h00, 1'b1);
        for (int i = 1; i <= 129; i++) begin
            tick();
            expect_pc("seq", 7'(i), 1'b1);
        end

        // Relative branch backwards from 10
        bus.Jump = 1'b1; bus.JumpTarget = 7'h0F;
        tick(); idle();
        expect_pc("jmp0f", 7'h0F, 1'b0);
        tick();
        expect_pc("at10", 7'h10, 1'b1);
        bus.Branch = 1'b1; bus.BranchOffset = 7'h7C;
        tick(); idle();
        expect_pc("br", 7'h0C, 1'b0);
        tick();
        expect_pc("br_next", 7'h0D, 1'b1);

        // Call at 05 to 40, return from 42
        bus.Jump = 1'b1; bus.JumpTarget = 7'h04;
        tick(); idle();
        tick();
        expect_pc("at05", 7'h05, 1'b1);
        bus.Call = 1'b1; bus.JumpTarget = 7'h40;
        tick(); idle();
        expect_pc("call40", 7'h40, 1'b0);
        expect_cnt("call40", 1);
        tick(); tick();
        expect_pc("at42", 7'h42, 1'b1);
        bus.Return = 1'b1;
        tick(); idle();
        expect_pc("ret", 7'h06, 1'b0);
        expect_cnt("ret", 0);
        tick();
        expect_pc("ret_next", 7'h07, 1'b1);

        // Five back-to-back calls overflow a four-deep stack
        bus.Call = 1'b1;
        bus.JumpTarget = 7'h20; tick(); expect_pc("c1", 7'h20, 1'b0);
        bus.JumpTarget = 7'h30; tick(); expect_pc("c2", 7'h30, 1'b0);
        bus.JumpTarget = 7'h50; tick(); expect_pc("c3", 7'h50, 1'b0);
        bus.JumpTarget = 7'h60; tick(); expect_pc("c4", 7'h60, 1'b0);
        expect_cnt("c4", 4);
        chk("c4_ovf", 32'(bus.RsOverflow), 0);
        bus.JumpTarget = 7'h70; tick(); expect_pc("c5", 7'h70, 1'b0);
        expect_cnt("c5", 4);
        chk("c5_ovf", 32'(bus.RsOverflow), 1);
        idle();
        bus.Return = 1'b1;
        tick(); expect_pc("r1", 7'h61, 1'b0);
        tick(); expect_pc("r2", 7'h51, 1'b0);
        tick(); expect_pc("r3", 7'h31, 1'b0);
        tick(); expect_pc("r4", 7'h21, 1'b0);
        expect_cnt("r4", 0);
        chk("r4_unf", 32'(bus.RsUnderflow), 0);
        tick(); expect_pc("r5", 7'h22, 1'b0);
        expect_cnt("r5", 0);
        chk("r5_unf", 32'(bus.RsUnderflow), 1);
        idle();
        tick();
        expect_pc("r5_next", 7'h23, 1'b1);
        chk("sticky_ovf", 32'(bus.RsOverflow), 1);

        // Stall during FLUSH freezes everything, including a pending call
        bus.Jump = 1'b1; bus.JumpTarget = 7'h55;
        tick(); idle();
        expect_pc("jmp55", 7'h55, 1'b0);
        bus.Stall = 1'b1; bus.Call = 1'b1; bus.JumpTarget = 7'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_pc("stall", 7'h55, 1'b0);
            expect_cnt("stall", 0);
        end
        bus.Halt = 1'b1;
        tick(); idle();
        expect_pc("halt", 7'h55, 1'b0);
        chk("halt_halted", 32'(bus.Halted), 1);
        bus.Jump = 1'b1; bus.JumpTarget = 7'h11;
        tick(); tick(); idle();
        expect_pc("halted", 7'h55, 1'b0);
        chk("halted_stays", 32'(bus.Halted), 1);

        // Reset out of HALT with sticky flags set
        Reset = 1'b1;
        #2;
        expect_pc("rst2", 7'h00, 1'b0);
        chk("rst2_halted", 32'(bus.Halted), 0);
        chk("rst2_ovf", 32'(bus.RsOverflow), 0);
        chk("rst2_unf", 32'(bus.RsUnderflow), 0);
        tick();
        Reset = 1'b0;
        tick();
        expect_pc("boot2", 7'h00, 1'b1);

        // Call and Return together: only the Return happens
        bus.Call = 1'b1; bus.JumpTarget = 7'h25;
        tick(); idle();
        expect_pc("call25", 7'h25, 1'b0);
        expect_cnt("call25", 1);
        tick();
        expect_pc("at26", 7'h26, 1'b1);
        bus.Call = 1'b1; bus.Return = 1'b1; bus.JumpTarget = 7'h77;
        tick(); idle();
        expect_pc("callret", 7'h01, 1'b0);
        expect_cnt("callret", 0);
        chk("callret_unf", 32'(bus.RsUnderflow), 0);
        tick();
        expect_pc("callret_next", 7'h02, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
